// File: rtl/serial_subtractor_if.sv
// Start/done handshake and operand/result bundle for serial_subtractor.
// The ovf signal exists only when SERIAL_SUB_OVF_EN is defined.
interface serial_subtractor_if #(
   parameter int unsigned WIDTH = 8
) ();

   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             bin;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] diff;
   logic             bout;
`ifdef SERIAL_SUB_OVF_EN
   logic             ovf;
`endif

   modport master (
`ifdef SERIAL_SUB_OVF_EN
      input  ovf,
`endif
      output start, a, b, bin,
      input  busy, done, diff, bout
   );

   modport slave (
`ifdef SERIAL_SUB_OVF_EN
      output ovf,
`endif
      input  start, a, b, bin,
      output busy, done, diff, bout
   );

endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: diff = (a - b - bin) mod 2^WIDTH, one bit per clock, LSB first.
// Each bit uses a 3-to-8 minterm decode of {a_lsb, b_lsb, borrow}.
// Optional signed-overflow output enabled by defining SERIAL_SUB_OVF_EN.
module serial_subtractor #(
   parameter int unsigned WIDTH = 8
) (
   input logic             clk,
   input logic             rst_n,
   serial_subtractor_if.slave bus
);

   localparam int unsigned CntW = ($clog2(WIDTH + 1) < 1) ? 1 : $clog2(WIDTH + 1);

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StRun  = 2'd1,
      StDone = 2'd2
   } state_e;

   state_e            state_q, state_d;
   logic [WIDTH-1:0]  a_q, a_d;
   logic [WIDTH-1:0]  b_q, b_d;
   logic [WIDTH-1:0]  res_q, res_d;
   logic [WIDTH-1:0]  diff_q, diff_d;
   logic [CntW-1:0]   cnt_q, cnt_d;
   logic              borrow_q, borrow_d;
   logic              bout_q, bout_d;
`ifdef SERIAL_SUB_OVF_EN
   logic              ovf_q, ovf_d;
`endif

   logic [2:0]        idx;
   logic [7:0]        m;
   logic              dbit;
   logic              bbit;
   logic [WIDTH-1:0]  res_shift;
   logic              unused_m;

   // Per-bit full-subtractor via minterm decode, and result shifted in from the MSB side.
   always_comb begin
      idx       = {a_q[0], b_q[0], borrow_q};
      m         = 8'b0000_0001 << idx;
      dbit      = m[1] | m[2] | m[4] | m[7];
      bbit      = m[1] | m[2] | m[3] | m[7];
      res_shift = res_q >> 1;
      res_shift[WIDTH-1] = dbit;
   end

   assign unused_m = ^{m[0], m[5], m[6]};

   // Next-state and datapath updates; IDLE and DONE both accept a new request.
   always_comb begin
      state_d  = state_q;
      a_d      = a_q;
      b_d      = b_q;
      res_d    = res_q;
      cnt_d    = cnt_q;
      borrow_d = borrow_q;
      diff_d   = diff_q;
      bout_d   = bout_q;
`ifdef SERIAL_SUB_OVF_EN
      ovf_d    = ovf_q;
`endif
      unique case (state_q)
         StIdle, StDone: begin
            if (bus.start) begin
               a_d      = bus.a;
               b_d      = bus.b;
               borrow_d = bus.bin;
               res_d    = '0;
               cnt_d    = '0;
               state_d  = StRun;
            end else begin
               state_d  = StIdle;
            end
         end
         StRun: begin
            a_d      = a_q >> 1;
            b_d      = b_q >> 1;
            borrow_d = bbit;
            res_d    = res_shift;
            cnt_d    = cnt_q + CntW'(1);
            if (cnt_q == CntW'(WIDTH - 1)) begin
               state_d = StDone;
               diff_d  = res_shift;
               bout_d  = bbit;
`ifdef SERIAL_SUB_OVF_EN
               // borrow_q is the borrow into the MSB on this last cycle
               ovf_d   = borrow_q ^ bbit;
`endif
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // State and datapath registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= StIdle;
         a_q      <= '0;
         b_q      <= '0;
         res_q    <= '0;
         cnt_q    <= '0;
         borrow_q <= 1'b0;
         diff_q   <= '0;
         bout_q   <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
         ovf_q    <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         a_q      <= a_d;
         b_q      <= b_d;
         res_q    <= res_d;
         cnt_q    <= cnt_d;
         borrow_q <= borrow_d;
         diff_q   <= diff_d;
         bout_q   <= bout_d;
`ifdef SERIAL_SUB_OVF_EN
         ovf_q    <= ovf_d;
`endif
      end
   end

   assign bus.busy = (state_q == StRun);
   assign bus.done = (state_q == StDone);
   assign bus.diff = diff_q;
   assign bus.bout = bout_q;
`ifdef SERIAL_SUB_OVF_EN
   assign bus.ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Bench for serial_subtractor: WIDTH=8 and WIDTH=1 instances against an arithmetic model.
module tb_serial_subtractor;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_n;
   logic chk_en = 1'b0;

   serial_subtractor_if #(.WIDTH(8)) if8 ();
   serial_subtractor_if #(.WIDTH(1)) if1 ();

   serial_subtractor #(.WIDTH(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(if8.slave));
   serial_subtractor #(.WIDTH(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1.slave));

   logic       st[2];
   logic [7:0] av[2];
   logic [7:0] bv[2];
   logic       bi[2];

   assign if8.start = st[0];
   assign if8.a     = av[0];
   assign if8.b     = bv[0];
   assign if8.bin   = bi[0];
   assign if1.start = st[1];
   assign if1.a     = av[1][0];
   assign if1.b     = bv[1][0];
   assign if1.bin   = bi[1];

   logic       act_busy[2];
   logic       act_done[2];
   logic       act_bout[2];
   logic       act_ovf[2];
   logic [7:0] act_diff[2];

   assign act_busy[0] = if8.busy;
   assign act_done[0] = if8.done;
   assign act_bout[0] = if8.bout;
   assign act_diff[0] = if8.diff;
   assign act_busy[1] = if1.busy;
   assign act_done[1] = if1.done;
   assign act_bout[1] = if1.bout;
   assign act_diff[1] = {7'b0, if1.diff};
`ifdef SERIAL_SUB_OVF_EN
   assign act_ovf[0] = if8.ovf;
   assign act_ovf[1] = if1.ovf;
`else
   assign act_ovf[0] = 1'b0;
   assign act_ovf[1] = 1'b0;
`endif

   int errors = 0;
   int checks = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: remaining busy cycles plus pending arithmetic result per instance.
   int         m_left[2];
   logic       m_done[2];
   logic       m_bout[2];
   logic       m_ovf[2];
   logic [7:0] m_diff[2];
   logic       p_bout[2];
   logic       p_ovf[2];
   logic [7:0] p_diff[2];

   initial begin
      for (int i = 0; i < 2; i++) begin
         m_left[i] = 0; m_done[i] = 0; m_bout[i] = 0; m_ovf[i] = 0; m_diff[i] = '0;
         p_bout[i] = 0; p_ovf[i] = 0; p_diff[i] = '0;
      end
   end

   always @(posedge clk) begin
      for (int i = 0; i < 2; i++) begin
         automatic int w   = (i == 0) ? 8 : 1;
         automatic int md  = 1 << w;
         automatic int ua  = int'(av[i]) % md;
         automatic int ub  = int'(bv[i]) % md;
         automatic int ubi = int'(bi[i]);
         automatic int u   = ua - ub - ubi;
         automatic int sa  = (ua >= md / 2) ? ua - md : ua;
         automatic int sb  = (ub >= md / 2) ? ub - md : ub;
         automatic int s   = sa - sb - ubi;
         if (!rst_n) begin
            m_left[i] <= 0;
            m_done[i] <= 1'b0;
            m_diff[i] <= '0;
            m_bout[i] <= 1'b0;
            m_ovf[i]  <= 1'b0;
         end else if (m_left[i] > 0) begin
            m_left[i] <= m_left[i] - 1;
            m_done[i] <= (m_left[i] == 1);
            if (m_left[i] == 1) begin
               m_diff[i] <= p_diff[i];
               m_bout[i] <= p_bout[i];
               m_ovf[i]  <= p_ovf[i];
            end
         end else begin
            m_done[i] <= 1'b0;
            if (st[i] === 1'b1) begin
               m_left[i] <= w;
               p_diff[i] <= 8'((u + md) % md);
               p_bout[i] <= (u < 0);
               p_ovf[i]  <= (s < -(md / 2)) || (s > md / 2 - 1);
            end
         end
      end
   end

   // Every-cycle comparison of both instances against the model.
   always @(negedge clk) begin
      if (chk_en) begin
         for (int i = 0; i < 2; i++) begin
            check($sformatf("busy[%0d]", i), 32'(act_busy[i]), 32'(m_left[i] != 0));
            check($sformatf("done[%0d]", i), 32'(act_done[i]), 32'(m_done[i]));
            check($sformatf("diff[%0d]", i), 32'(act_diff[i]), 32'(m_diff[i]));
            check($sformatf("bout[%0d]", i), 32'(act_bout[i]), 32'(m_bout[i]));
            check($sformatf("excl[%0d]", i), 32'(act_busy[i] & act_done[i]), 32'd0);
`ifdef SERIAL_SUB_OVF_EN
            check($sformatf("ovf[%0d]", i), 32'(act_ovf[i]), 32'(m_ovf[i]));
`endif
         end
      end
   end

   // Issue one operation from a negedge; return at the negedge where done is seen.
   task automatic do_op(input int i, input logic [7:0] a, input logic [7:0] b,
                        input logic bin, output int lat);
      st[i] = 1'b1;
      av[i] = a;
      bv[i] = b;
      bi[i] = bin;
      @(negedge clk);
      st[i] = 1'b0;
      lat = 1;
      while (act_done[i] !== 1'b1 && lat < 30) begin
         @(negedge clk);
         lat++;
      end
   endtask

   int         lat;
   int         npulse;
   logic [7:0] btab;

   initial begin
      for (int i = 0; i < 2; i++) begin
         st[i] = 1'b0; av[i] = '0; bv[i] = '0; bi[i] = 1'b0;
      end
      rst_n = 1'b0;
      @(negedge clk);
      chk_en = 1'b1;
      check("rst_busy", 32'(act_busy[0]), 32'd0);
      check("rst_diff", 32'(act_diff[0]), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // Directed: basic subtraction and latency
      do_op(0, 8'h35, 8'h12, 1'b0, lat);
      check("lat8", 32'(lat), 32'd9);
      check("t1_diff", 32'(act_diff[0]), 32'h23);
      check("t1_bout", 32'(act_bout[0]), 32'd0);
`ifdef SERIAL_SUB_OVF_EN
      check("t1_ovf", 32'(act_ovf[0]), 32'd0);
`endif
      do_op(0, 8'h00, 8'h01, 1'b0, lat);
      check("t2_diff", 32'(act_diff[0]), 32'hFF);
      check("t2_bout", 32'(act_bout[0]), 32'd1);
`ifdef SERIAL_SUB_OVF_EN
      check("t2_ovf", 32'(act_ovf[0]), 32'd0);
`endif
      do_op(0, 8'h10, 8'h0F, 1'b1, lat);
      check("t3_diff", 32'(act_diff[0]), 32'h00);
      check("t3_bout", 32'(act_bout[0]), 32'd0);
`ifdef SERIAL_SUB_OVF_EN
      do_op(0, 8'h80, 8'h01, 1'b0, lat);
      check("t4_diff", 32'(act_diff[0]), 32'h7F);
      check("t4_bout", 32'(act_bout[0]), 32'd0);
      check("t4_ovf", 32'(act_ovf[0]), 32'd1);
      do_op(0, 8'h7F, 8'hFF, 1'b0, lat);
      check("t5_diff", 32'(act_diff[0]), 32'h80);
      check("t5_bout", 32'(act_bout[0]), 32'd1);
      check("t5_ovf", 32'(act_ovf[0]), 32'd1);
`endif
      @(negedge clk);

      // Start while busy is ignored
      st[0] = 1'b1; av[0] = 8'h35; bv[0] = 8'h12; bi[0] = 1'b0;
      @(negedge clk);
      st[0] = 1'b0;
      @(negedge clk);
      @(negedge clk);
      st[0] = 1'b1; av[0] = 8'hFF;
      @(negedge clk);
      st[0] = 1'b0;
      npulse = 0;
      for (int c = 0; c < 15; c++) begin
         if (act_done[0] === 1'b1) npulse++;
         @(negedge clk);
      end
      check("ign_pulses", 32'(npulse), 32'd1);
      check("ign_diff", 32'(act_diff[0]), 32'h23);

      // Reset in the middle of RUN
      st[0] = 1'b1; av[0] = 8'hA5; bv[0] = 8'h3C;
      @(negedge clk);
      st[0] = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      check("mrst_busy", 32'(act_busy[0]), 32'd0);
      check("mrst_diff", 32'(act_diff[0]), 32'd0);
      check("mrst_done", 32'(act_done[0]), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);
      check("mrst_nodone", 32'(act_done[0]), 32'd0);
      do_op(0, 8'h35, 8'h12, 1'b0, lat);
      check("post_rst_diff", 32'(act_diff[0]), 32'h23);

      // WIDTH=1 truth table
      btab = 8'b1000_1110;
      for (int k = 0; k < 8; k++) begin
         automatic logic [2:0] kv = 3'(k);
         @(negedge clk);
         do_op(1, {7'b0, kv[2]}, {7'b0, kv[1]}, kv[0], lat);
         check($sformatf("w1_lat%0d", k), 32'(lat), 32'd2);
         check($sformatf("w1_diff%0d", k), 32'(act_diff[1]), 32'(kv[2] ^ kv[1] ^ kv[0]));
         check($sformatf("w1_bout%0d", k), 32'(act_bout[1]), 32'(btab[k]));
      end

      // Random traffic on both instances; operands change every cycle
      for (int c = 0; c < 800; c++) begin
         @(negedge clk);
         for (int i = 0; i < 2; i++) begin
            st[i] = ($urandom_range(0, 3) == 0);
            av[i] = 8'($urandom);
            bv[i] = 8'($urandom);
            bi[i] = 1'($urandom);
         end
      end

      // Back-to-back with start held high
      for (int c = 0; c < 60; c++) begin
         @(negedge clk);
         for (int i = 0; i < 2; i++) begin
            st[i] = 1'b1;
            av[i] = 8'($urandom);
            bv[i] = 8'($urandom);
            bi[i] = 1'($urandom);
         end
      end
      @(negedge clk);
      st[0] = 1'b0;
      st[1] = 1'b0;
      repeat (12) @(negedge clk);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/serial_subtractor.md
# serial_subtractor

Parametrised bit-serial subtractor that computes `a - b - bin` over `WIDTH` bits, one bit per clock. It is the sequential successor to the team's single-bit decoder-based full subtractor: each cycle evaluates one bit position with the same minterm logic (3-to-8 decode, diff = m1|m2|m4|m7, borrow = m1|m2|m3|m7). A registered borrow carries the result between cycles. It sits in the arithmetic datapath wherever area matters more than latency and is driven by a start/done handshake.

## Interface
- `WIDTH`, default 8: operand and result width in bits; legal range ≥ 1.
- `clk`  input  1: single clock, rising-edge.
- `rst_n`  input  1: synchronous, active-low reset.
- `start`  input  1: request; sampled only when `busy` = 0.
- `a`  input  `WIDTH`: minuend; captured on the accepting edge.
- `b`  input  `WIDTH`: subtrahend; captured on the accepting edge.
- `bin`  input  1: borrow-in; captured on the accepting edge.
- `busy`  output  1: operation in progress.
- `done`  output  1: one-cycle completion pulse.
- `diff`  output  `WIDTH`: result register, `(a - b - bin) mod 2^WIDTH`.
- `bout`  output  1: borrow-out of the MSB.
- `ovf`  output  1: signed overflow. Present only with `SERIAL_SUB_OVF_EN`.

## Operation
- States: IDLE, RUN, DONE.
- IDLE: `busy` = 0. When `start` = 1, load shift registers with `a` and `b`, load the borrow register with `bin`, clear the bit counter, and go to RUN.
- RUN: `busy` = 1. Each cycle:
  - Compute diff/borrow from {a_lsb, b_lsb, borrow} with the decoder-minterm equations.
  - Shift the diff bit into the internal result shift register from the MSB side.
  - Shift both operand registers right by one and update the borrow register.
  - Increment the counter.
- On the cycle that processes bit `WIDTH-1`, go to DONE. On that same edge, copy the full result into `diff` and the final borrow into `bout`.
- DONE: `done` = 1 and `busy` = 0 for exactly one cycle.
  - If `start` = 1 in DONE, accept a new operation (load as in IDLE) and go to RUN.
  - Otherwise go to IDLE.
- `start` while `busy` = 1 is ignored; no queuing.
- `diff`, `bout` and `ovf` change only on the completion edge. They hold their values through IDLE and through the next operation until that operation completes.
- Counter width is `$clog2(WIDTH+1)`, minimum 1. `WIDTH` = 1 performs a single RUN cycle.
- Operands are unsigned for `diff`/`bout`. Input changes after the accepting edge have no effect.

## Timing
- Reset (`rst_n` = 0 at a rising edge): state IDLE, `busy` = 0, `done` = 0, `diff` = 0, `bout` = 0, `ovf` = 0, counter and shift registers = 0.
- Reset mid-operation aborts the operation: no `done` pulse, and outputs return to reset values.
- Latency, with the accepting edge as E0:
  - `busy` = 1 during the `WIDTH` cycles following E0.
  - Results update at E`WIDTH`.
  - `done` = 1 in the cycle following E`WIDTH`.
- Back-to-back throughput: one result per `WIDTH+1` cycles, with `start` held high.
- `done` and `busy` are never high together.

## Configuration
- `SERIAL_SUB_OVF_EN` defined:
  - The `ovf` port exists.
  - At the start of the last RUN cycle, the borrow register holds the borrow into the MSB.
  - `ovf` = that borrow XOR `bout`, registered at the completion edge with `diff`.
  - Reset value 0.
- Not defined: the `ovf` port and its logic are absent. All other behaviour is identical.

## Test plan
- `WIDTH`=8, a=0x35, b=0x12, bin=0, start pulse → `busy` for 8 cycles, then `done` pulse; `diff`=0x23, `bout`=0, `ovf`=0.
- `WIDTH`=8, a=0x00, b=0x01, bin=0 → `diff`=0xFF, `bout`=1, `ovf`=0. Then a=0x10, b=0x0F, bin=1 → `diff`=0x00, `bout`=0.
- `WIDTH`=8 with `SERIAL_SUB_OVF_EN`, a=0x80, b=0x01, bin=0 → `diff`=0x7F, `bout`=0, `ovf`=1. Then a=0x7F, b=0xFF → `diff`=0x80, `bout`=1, `ovf`=1.
- `WIDTH`=8, a=0x35, b=0x12 accepted, then `start` re-asserted with a=0xFF at cycle 3 → ignored. `diff`=0x23 at completion, and there is exactly one `done` pulse.
- `WIDTH`=8: `rst_n` low at cycle 4 of RUN → next cycle `busy`=0, `diff`=0x00, no `done`. A new operation after reset completes correctly.
- `WIDTH`=1, all 8 combinations of {a, b, bin} → `diff`/`bout` match the full-subtractor truth table (diff = a^b^bin; borrow asserted for 001, 010, 011, 111). `done` arrives 2 cycles after each accept.
